hex_display_bank: RTL and testbench
===================================

Name: hex_display_bank

Overview:
Parametrised multi-digit hex display driver for the board's active-low 7-segment displays. It captures a packed value on a load strobe and drives DIGITS displays with corrected glyphs for 0-F. It adds three behaviours the single-digit decoder lacks: a power-on lamp test, an optional blink mode, and optional leading-zero blanking. It sits between datapath or lab logic and the HEX0..HEX5 pins.

Parameters:
DIGITS, 6, number of displays driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=1)
LAMP_CYCLES, 50000000, cycles of all-segments-on after reset (0 = skip lamp test)

Ports:
CLOCK_50  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
load  in  1  capture data this cycle
data  in  4*DIGITS  packed nibbles; digit i = data[4i+3:4i], digit 0 least significant
blink_en  in  1  enable blinking of the whole display
busy  out  1  high while the lamp test runs
segs  out  7*DIGITS  active-low segments; digit i = segs[7i+6:7i], bit order {g,f,e,d,c,b,a}

Behaviour:
- One clock; reset is synchronous and active-low: resetn sampled low at a CLOCK_50 rising edge resets the block.
- Reset values:
  - value register = 0
  - blink counter = 0
  - blink phase = 0 (visible)
  - segs = all 1s (blank)
  - busy = 1 if LAMP_CYCLES>0, else 0
  - FSM = LAMP if LAMP_CYCLES>0, else RUN
- FSM states:
  - LAMP: lamp counter counts 0..LAMP_CYCLES-1. segs = all 0s (every segment lit). busy=1. Moves to RUN on the edge where the count reaches LAMP_CYCLES-1.
  - RUN: normal display. busy=0. No exit except reset.
- Load:
  - data is captured into the value register on any edge with load=1, including in LAMP.
  - In LAMP the captured value shows on the first RUN cycle.
- Latency: load sampled at edge k; segs show the new glyphs after edge k+1. segs is a registered output.
- Glyph table (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blink:
  - blink_en=0: counter held at 0, phase held at 0.
  - blink_en=1: counter increments each cycle. At BLINK_DIV-1 it wraps to 0 and the phase toggles.
  - phase=1: all digits blank (1111111).
  - A load with blink_en=1 clears the counter and phase, so the new value is visible immediately for a full half-period.
  - Blink has no effect in LAMP; the counter is held during LAMP.
- Simultaneous events:
  - resetn low overrides load and blink_en.
  - load and the blink wrap on the same edge: load wins (phase 0, counter 0).
- Reset during RUN: segs blank on the next edge, then the lamp test restarts.
- Counter widths: $clog2 of their limit, minimum 1 bit. No overflow beyond the wrap values.

Optional Feature:
HEXDISP_LZB_EN, leading-zero blanking.
- Defined:
  - Every digit above the most significant nonzero nibble is blanked (1111111).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Applied in RUN only; blink blanking still overrides.
- Not defined: all DIGITS digits always show glyphs, including leading zeros.

Test Plan (DIGITS=6, BLINK_DIV=4, LAMP_CYCLES=3 overrides):
- Reset then idle: after resetn goes high, busy=1 and segs=0 for 3 cycles. Then busy=0 and segs shows digit 0 = 1000000 in every digit.
- Sweep: load data=0x543210, then 0xFEDCBA. Two edges after each load, every digit matches the glyph table (e.g. digit 0 of the second load = 0001000).
- Load during LAMP: assert load with data=0x000009 in the second LAMP cycle. The first RUN cycle shows digit 0 = 0010000; without HEXDISP_LZB_EN, digits 1-5 show 1000000.
- Blink: blink_en=1 with value 0x000001. segs alternates visible/blank every 4 cycles. A load of 0x000002 mid-blank makes the display visible two edges later, with digit 0 = 0100100, for 4 cycles.
- Reset mid-blink: drive resetn low for one edge during a blank phase. segs = all 1s next edge, then the lamp test, then value 0.
- HEXDISP_LZB_EN defined: load 0x000A30. Digits 5..3 = 1111111, digit 2 = 0001000, digit 1 = 0110000, digit 0 = 1000000. Load 0 -> only digit 0 lit (1000000).

Source files
------------

// File: rtl/hex_display_bank.sv
// Multi-digit active-low 7-segment driver: load-captured value, power-on lamp test, blink.
// Define HEXDISP_LZB_EN to blank leading zeros in normal display.
module hex_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7f;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'ha: seg = 7'b0001000;
        4'hb: seg = 7'b0000011;
        4'hc: seg = 7'b1000110;
        4'hd: seg = 7'b0100001;
        4'he: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module hex_display_bank #(
  parameter int DIGITS      = 6,
  parameter int BLINK_DIV   = 25000000,
  parameter int LAMP_CYCLES = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  blink_en,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   segs
);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int LW = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);
  localparam logic [LW-1:0] LLAST = LW'(LAMP_CYCLES - 1);

  typedef enum logic {LAMP, RUN} state_t;

  state_t                   state;
  logic [DIGITS-1:0][3:0]   val;
  logic [DIGITS-1:0][6:0]   glyph;
  logic [DIGITS-1:0]        lzb;
  logic [BW-1:0]            bcnt;
  logic [LW-1:0]            lcnt;
  logic                     phase;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_lane
`ifdef HEXDISP_LZB_EN
      // digit 0 always shows, so a zero value still reads "0"
      if (i == 0) begin : g_lsd
        assign lzb[i] = 1'b0;
      end else begin : g_upper
        assign lzb[i] = ~|val[DIGITS-1:i];
      end
`else
      assign lzb[i] = 1'b0;
`endif
      hex_digit u_dig (.nib(val[i]), .blank(lzb[i]), .seg(glyph[i]));
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      val   <= '0;
      bcnt  <= '0;
      lcnt  <= '0;
      phase <= 1'b0;
      segs  <= '1;
      busy  <= (LAMP_CYCLES > 0);
      state <= (LAMP_CYCLES > 0) ? LAMP : RUN;
    end else begin
      if (load) val <= data;
      case (state)
        LAMP: begin
          segs <= '0;
          // blink counter stays parked; a load can only re-clear it
          if (load || !blink_en) begin
            bcnt  <= '0;
            phase <= 1'b0;
          end
          if (lcnt == LLAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        default: begin
          segs <= phase ? '1 : glyph;
          if (!blink_en || load) begin
            bcnt  <= '0;
            phase <= 1'b0;
          end else if (bcnt == BLAST) begin
            bcnt  <= '0;
            phase <= ~phase;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank (DIGITS=6, BLINK_DIV=4, LAMP_CYCLES=3).
module tb_hex_display_bank;
  localparam int D = 6;

  logic            clk = 1'b0;
  logic            resetn, load, blink_en, busy;
  logic [4*D-1:0]  data;
  logic [7*D-1:0]  segs;
  int              checks = 0;
  int              errors = 0;

  localparam logic [7*D-1:0] BLANK = '1;
  localparam logic [7*D-1:0] LIT   = '0;

  hex_display_bank #(.DIGITS(D), .BLINK_DIV(4), .LAMP_CYCLES(3)) dut (
    .CLOCK_50(clk), .resetn(resetn), .load(load), .data(data),
    .blink_en(blink_en), .busy(busy), .segs(segs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] gl(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [7*D-1:0] exp_segs(input logic [4*D-1:0] v);
    logic [7*D-1:0] r;
    logic [4*D-1:0] sh;
    r = '0;
    for (int i = 0; i < D; i++) begin
      sh = v >> (4 * i);
      r[7*i +: 7] = gl(v[4*i +: 4]);
`ifdef HEXDISP_LZB_EN
      if (i > 0 && sh == '0) r[7*i +: 7] = 7'h7f;
`endif
    end
    return r;
  endfunction

  task automatic do_load(input logic [4*D-1:0] v);
    data = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; load = 1'b0; blink_en = 1'b0; data = '0;
    tick();
    chk("rst_segs", segs, BLANK);
    chk("rst_busy", busy, 1);
    resetn = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("lamp_segs", segs, LIT);
      chk("lamp_busy", busy, (n < 3) ? 1 : 0);
    end
    tick();
    chk("idle_zero", segs, exp_segs('0));
    chk("idle_busy", busy, 0);

    do_load(24'h543210);
    tick();
    chk("sweep_lo", segs, exp_segs(24'h543210));
    chk("sweep_lo_d5", segs[41:35], 7'b0010010);
    do_load(24'hFEDCBA);
    tick();
    chk("sweep_hi", segs, exp_segs(24'hFEDCBA));
    chk("sweep_hi_d0", segs[6:0], 7'b0001000);

    // load in the second lamp cycle
    resetn = 1'b0;
    tick();
    chk("rst2_segs", segs, BLANK);
    resetn = 1'b1;
    tick();
    do_load(24'h000009);
    tick();
    chk("lampload_still_lit", segs, LIT);
    tick();
    chk("lampload_show", segs, exp_segs(24'h000009));
    chk("lampload_d0", segs[6:0], 7'b0010000);
`ifndef HEXDISP_LZB_EN
    chk("lampload_d5", segs[41:35], 7'b1000000);
`endif

    // blink: 4 visible, 4 blank
    blink_en = 1'b1;
    do_load(24'h000001);
    for (int n = 1; n <= 14; n++) begin
      tick();
      chk($sformatf("blink_%0d", n), segs,
          (((n - 1) / 4) % 2 == 0) ? exp_segs(24'h000001) : BLANK);
    end
    do_load(24'h000002);
    chk("blink_loadedge", segs, BLANK);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("blink_new_%0d", n), segs, exp_segs(24'h000002));
    end
    tick();
    chk("blink_new_blank", segs, BLANK);

    // reset during blank phase
    resetn = 1'b0;
    tick();
    chk("rst3_segs", segs, BLANK);
    chk("rst3_busy", busy, 1);
    resetn = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("lamp3_segs", segs, LIT);
    end
    tick();
    chk("rst3_val0", segs, exp_segs('0));
    blink_en = 1'b0;

    do_load(24'h000A30);
    tick();
    chk("lzb_a30", segs, exp_segs(24'h000A30));
    chk("lzb_d2", segs[20:14], 7'b0001000);
`ifdef HEXDISP_LZB_EN
    chk("lzb_top", segs[41:21], 21'h1FFFFF);
`else
    chk("nolzb_top", segs[41:21], {3{7'b1000000}});
`endif
    do_load(24'h000000);
    tick();
    chk("lzb_zero", segs, exp_segs('0));
    chk("lzb_zero_d0", segs[6:0], 7'b1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
